blink_tick_ctrl: RTL and testbench



---
 rtl/blink_tick_ctrl.sv | 151 +++++++++++++++
 tb/tb_blink_tick_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_tick_ctrl.sv
// rtl/blink_tick_ctrl.sv - key debounce and rate-selectable tick generator for the LED blinker
//
// Purpose: synchronizes and debounces two active-low push-buttons, turns each
// debounced press into a single event, and produces a one-cycle TICK strobe
// every (HALF_PERIOD >> SPEED) cycles unless paused.
//
// Ports:
//   CLOCK_50    in   1  only clock, rising edge
//   RESET       in   1  asynchronous, active-high reset
//   KEY_SPEED_N in   1  raw speed button, 0 = pressed, asynchronous
//   KEY_PAUSE_N in   1  raw pause button, 0 = pressed, asynchronous
//   TICK        out  1  one-cycle strobe, registered
//   SPEED       out  2  current rate index 0..3, registered
//   PAUSED      out  1  1 = tick generation frozen, registered
`timescale 1ns/1ps

module blink_tick_ctrl #(
  parameter int unsigned HALF_PERIOD  = 50000000,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_SPEED_N,
  input  logic       KEY_PAUSE_N,
  output logic       TICK,
  output logic [1:0] SPEED,
  output logic       PAUSED
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(HALF_PERIOD);

  // Two-flop synchronizers
  logic spd_s1_q, spd_s1_d, spd_s2_q, spd_s2_d;
  logic pse_s1_q, pse_s1_d, pse_s2_q, pse_s2_d;

  // Debounced key state, its one-cycle-delayed copy for edge detect, counters
  logic             spd_db_q, spd_db_d, spd_dbp_q, spd_dbp_d;
  logic             pse_db_q, pse_db_d, pse_dbp_q, pse_dbp_d;
  logic [CNT_W-1:0] spd_cnt_q, spd_cnt_d;
  logic [CNT_W-1:0] pse_cnt_q, pse_cnt_d;

  // Prescaler and registered outputs
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [1:0]       speed_q, speed_d;
  logic             paused_q, paused_d;

  logic             speed_press;
  logic             pause_press;
  logic [CNT_W-1:0] period;

  always_comb begin
    spd_s1_d = KEY_SPEED_N;
    spd_s2_d = spd_s1_q;
    pse_s1_d = KEY_PAUSE_N;
    pse_s2_d = pse_s1_q;

    // Counter only runs while the synced key disagrees with the accepted
    // state; any agreement restarts the qualification window.
    spd_db_d  = spd_db_q;
    spd_cnt_d = '0;
    if (spd_s2_q != spd_db_q) begin
      if (spd_cnt_q == DEB_MAX) begin
        spd_db_d = spd_s2_q;
      end else begin
        spd_cnt_d = spd_cnt_q + CNT_ONE;
      end
    end

    pse_db_d  = pse_db_q;
    pse_cnt_d = '0;
    if (pse_s2_q != pse_db_q) begin
      if (pse_cnt_q == DEB_MAX) begin
        pse_db_d = pse_s2_q;
      end else begin
        pse_cnt_d = pse_cnt_q + CNT_ONE;
      end
    end

    spd_dbp_d = spd_db_q;
    pse_dbp_d = pse_db_q;

    // Press = debounced 1->0; release is deliberately ignored
    speed_press = spd_dbp_q & ~spd_db_q;
    pause_press = pse_dbp_q & ~pse_db_q;

    period = HALF >> speed_q;

    speed_d  = speed_q;
    paused_d = paused_q ^ pause_press;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;

    // A speed change restarts the period and swallows a coincident tick.
    // Pause uses the current paused_q, so a pause landing on the wrap still
    // lets that tick out and a resume starts counting the cycle after.
    if (speed_press) begin
      speed_d = speed_q + 2'd1;
      cnt_d   = '0;
    end else if (!paused_q) begin
      if (cnt_q == period - CNT_ONE) begin
        tick_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      spd_s1_q  <= 1'b1;
      spd_s2_q  <= 1'b1;
      pse_s1_q  <= 1'b1;
      pse_s2_q  <= 1'b1;
      spd_db_q  <= 1'b1;
      spd_dbp_q <= 1'b1;
      pse_db_q  <= 1'b1;
      pse_dbp_q <= 1'b1;
      spd_cnt_q <= '0;
      pse_cnt_q <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      speed_q   <= 2'd0;
      paused_q  <= 1'b0;
    end else begin
      spd_s1_q  <= spd_s1_d;
      spd_s2_q  <= spd_s2_d;
      pse_s1_q  <= pse_s1_d;
      pse_s2_q  <= pse_s2_d;
      spd_db_q  <= spd_db_d;
      spd_dbp_q <= spd_dbp_d;
      pse_db_q  <= pse_db_d;
      pse_dbp_q <= pse_dbp_d;
      spd_cnt_q <= spd_cnt_d;
      pse_cnt_q <= pse_cnt_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      speed_q   <= speed_d;
      paused_q  <= paused_d;
    end
  end

  assign TICK   = tick_q;
  assign SPEED  = speed_q;
  assign PAUSED = paused_q;

endmodule

// File: tb/tb_blink_tick_ctrl.sv
// tb/tb_blink_tick_ctrl.sv - directed self-checking bench for blink_tick_ctrl
`timescale 1ns/1ps

module tb_blink_tick_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_speed_n = 1'b1;
  logic       key_pause_n = 1'b1;
  logic       tick;
  logic [1:0] speed;
  logic       paused;

  int tests_run    = 0;
  int tests_failed = 0;

  always #1 clk = ~clk;

  blink_tick_ctrl #(
    .HALF_PERIOD (16),
    .DEBOUNCE_CYC(4),
    .CNT_W       (32)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .KEY_SPEED_N(key_speed_n),
    .KEY_PAUSE_N(key_pause_n),
    .TICK       (tick),
    .SPEED      (speed),
    .PAUSED     (paused)
  );

  // Returns the number of falling edges until TICK is seen, or -1 on timeout
  task automatic wait_tick(input int max_cyc, output int n);
    n = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick got %b want 0", tick); end
    tests_run++;
    if (speed !== 2'd0) begin tests_failed++; $display("FAIL reset_speed got %0d want 0", speed); end
    tests_run++;
    if (paused !== 1'b0) begin tests_failed++; $display("FAIL reset_paused got %b want 0", paused); end
    rst = 1'b0;
    wait_tick(40, n);
    tests_run++;
    if (n != 16) begin tests_failed++; $display("FAIL first_tick got %0d want 16", n); end
    @(negedge clk);
    tests_run++;
    if (tick !== 1'b0) begin tests_failed++; $display("FAIL tick_width got %b want 0", tick); end
    wait_tick(40, n);
    tests_run++;
    if (n != 15) begin tests_failed++; $display("FAIL tick_period0 got %0d want 15", n); end
    tests_run++;
    if (speed !== 2'd0 || paused !== 1'b0) begin
      tests_failed++; $display("FAIL idle_state got speed=%0d paused=%b want 0/0", speed, paused);
    end
  endtask

  task automatic test_speed;
    int n;
    int first;
    logic [1:0] old_s, new_s;
    int per;
    for (int i = 0; i < 4; i++) begin
      old_s = 2'(i);
      new_s = 2'(i + 1);
      per   = 16 >> new_s;
      first = -1;
      key_speed_n = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (k == 7) begin
          tests_run++;
          if (speed !== old_s) begin tests_failed++; $display("FAIL speed_early[%0d] got %0d want %0d", i, speed, old_s); end
        end
        if (k == 8) begin
          tests_run++;
          if (speed !== new_s) begin tests_failed++; $display("FAIL speed_step[%0d] got %0d want %0d", i, speed, new_s); end
        end
        if (k > 8 && tick === 1'b1 && first < 0) first = k;
        if (k == 20) key_speed_n = 1'b1;
      end
      tests_run++;
      if (first != 8 + per) begin tests_failed++; $display("FAIL speed_first_tick[%0d] got %0d want %0d", i, first, 8 + per); end
      tests_run++;
      if (speed !== new_s) begin tests_failed++; $display("FAIL speed_hold[%0d] got %0d want %0d", i, speed, new_s); end
      wait_tick(40, n);
      wait_tick(40, n);
      tests_run++;
      if (n != per) begin tests_failed++; $display("FAIL speed_period[%0d] got %0d want %0d", i, n, per); end
    end
  endtask

  task automatic test_bounce;
    int n;
    int first;
    wait_tick(40, n);
    first = -1;
    key_speed_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) key_speed_n = 1'b1;
      if (k == 5) key_speed_n = 1'b0;
      if (k == 8) key_speed_n = 1'b1;
      if (tick === 1'b1 && first < 0) first = k;
    end
    tests_run++;
    if (first != 16) begin tests_failed++; $display("FAIL bounce_tick got %0d want 16", first); end
    tests_run++;
    if (speed !== 2'd0) begin tests_failed++; $display("FAIL bounce_speed got %0d want 0", speed); end
    wait_tick(40, n);
    tests_run++;
    if (n != 12) begin tests_failed++; $display("FAIL bounce_next_tick got %0d want 12", n); end
  endtask

  task automatic test_pause;
    int n;
    int ticks;
    int first;
    wait_tick(40, n);
    repeat (3) @(negedge clk);
    // Press pulse lands while the prescaler holds 10
    key_pause_n = 1'b0;
    ticks = 0;
    for (int k = 1; k <= 108; k++) begin
      @(negedge clk);
      if (k == 7) begin
        tests_run++;
        if (paused !== 1'b0) begin tests_failed++; $display("FAIL pause_early got %b want 0", paused); end
      end
      if (k == 8) begin
        tests_run++;
        if (paused !== 1'b1) begin tests_failed++; $display("FAIL pause_set got %b want 1", paused); end
      end
      if (k == 20) key_pause_n = 1'b1;
      if (tick === 1'b1) ticks++;
    end
    tests_run++;
    if (ticks != 0) begin tests_failed++; $display("FAIL pause_silent got %0d ticks want 0", ticks); end
    key_pause_n = 1'b0;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 7) begin
        tests_run++;
        if (paused !== 1'b1) begin tests_failed++; $display("FAIL resume_early got %b want 1", paused); end
      end
      if (k == 8) begin
        tests_run++;
        if (paused !== 1'b0) begin tests_failed++; $display("FAIL resume_clear got %b want 0", paused); end
      end
      if (tick === 1'b1 && first < 0) first = k;
    end
    key_pause_n = 1'b1;
    tests_run++;
    if (first != 13) begin tests_failed++; $display("FAIL resume_tick got %0d want 13", first); end
    wait_tick(40, n);
    tests_run++;
    if (n != 9) begin tests_failed++; $display("FAIL resume_period got %0d want 9", n); end
  endtask

  task automatic test_speed_collide;
    int n;
    int first;
    wait_tick(40, n);
    repeat (8) @(negedge clk);
    // Press pulse lands while the prescaler holds 15
    key_speed_n = 1'b0;
    first = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 8) begin
        tests_run++;
        if (tick !== 1'b0) begin tests_failed++; $display("FAIL collide_tick got %b want 0", tick); end
        tests_run++;
        if (speed !== 2'd1) begin tests_failed++; $display("FAIL collide_speed got %0d want 1", speed); end
      end
      if (k == 20) key_speed_n = 1'b1;
      if (tick === 1'b1 && first < 0) first = k;
    end
    tests_run++;
    if (first != 16) begin tests_failed++; $display("FAIL collide_next got %0d want 16", first); end
  endtask

  task automatic test_reset_mid;
    int n;
    key_speed_n = 1'b0;
    key_pause_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 8) begin
        tests_run++;
        if (speed !== 2'd2 || paused !== 1'b1) begin
          tests_failed++; $display("FAIL both_press got speed=%0d paused=%b want 2/1", speed, paused);
        end
      end
    end
    key_speed_n = 1'b1;
    key_pause_n = 1'b1;
    repeat (12) @(negedge clk);
    tests_run++;
    if (speed !== 2'd2 || paused !== 1'b1) begin
      tests_failed++; $display("FAIL pre_reset got speed=%0d paused=%b want 2/1", speed, paused);
    end
    #0.5;
    rst = 1'b1;
    #0.2;
    tests_run++;
    if (tick !== 1'b0 || speed !== 2'd0 || paused !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset got tick=%b speed=%0d paused=%b want 0/0/0", tick, speed, paused);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_tick(40, n);
    tests_run++;
    if (n != 16) begin tests_failed++; $display("FAIL post_reset_tick got %0d want 16", n); end
  endtask

  initial begin
    test_reset();
    test_speed();
    test_bounce();
    test_pause();
    test_speed_collide();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
